// File: rtl/mux_nx1_pipe.sv
// N-to-1 channel multiplexer with a registered output stage and one skid entry,
// plus a sticky out-of-range select flag and a 16-bit transfer counter.
module mux_nx1_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]      sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 err_clr,
    output logic                 sel_err,
    output logic [15:0]          xfer_cnt
);

    localparam int unsigned CMPW = SELW + 1;

    logic [WIDTH-1:0] skid_data;
    logic             skid_full;
    logic [WIDTH-1:0] sel_value;
    logic             sel_oor;
    logic             accept;
    logic             stage_free;
    logic             xfer;

    assign in_ready   = !skid_full;
    assign accept     = in_valid && !skid_full;
    assign stage_free = !out_valid || out_ready;
    assign xfer       = out_valid && out_ready;
    assign sel_oor    = ({1'b0, sel} >= CMPW'(N));

    // Out-of-range selects fall through to all-zero.
    always_comb begin
        sel_value = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (sel == SELW'(i)) begin
                sel_value = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register with one skid entry; skid drains before new input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            skid_data <= '0;
            skid_full <= 1'b0;
        end else if (stage_free) begin
            if (skid_full) begin
                out_data  <= skid_data;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_data  <= sel_value;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data <= sel_value;
            skid_full <= 1'b1;
        end
    end

    // Set wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (accept && sel_oor) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (xfer) begin
            xfer_cnt <= xfer_cnt + 16'(1);
        end
    end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: an N=4 instance for streaming, backpressure,
// reset and counter wrap, and an N=3 instance for the out-of-range select flag.
module tb_mux_nx1_pipe;

    localparam int unsigned W = 64;

    logic clk;
    logic rst_n;

    logic [4*W-1:0] in_data4;
    logic [1:0]     sel4;
    logic           in_valid4, in_ready4, out_valid4, out_ready4, err_clr4, sel_err4;
    logic [W-1:0]   out_data4;
    logic [15:0]    xfer_cnt4;

    logic [3*W-1:0] in_data3;
    logic [1:0]     sel3;
    logic           in_valid3, in_ready3, out_valid3, out_ready3, err_clr3, sel_err3;
    logic [W-1:0]   out_data3;
    logic [15:0]    xfer_cnt3;

    int checks;
    int failures;

    mux_nx1_pipe #(.WIDTH(W), .N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel4),
        .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .err_clr(err_clr4),
        .sel_err(sel_err4), .xfer_cnt(xfer_cnt4)
    );

    mux_nx1_pipe #(.WIDTH(W), .N(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .err_clr(err_clr3),
        .sel_err(sel_err3), .xfer_cnt(xfer_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic [63:0] data;
        logic        ordy;
        logic        ev;
        logic [63:0] ed;
        logic        er;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Channel i carries A0+i except the selected channel, which carries data.
    task automatic drive4(input logic iv, input logic [1:0] s, input logic [63:0] data,
                          input logic ordy);
        logic [4*W-1:0] d;
        for (int i = 0; i < 4; i++) d[i*W +: W] = 64'hA0 + 64'(i);
        d[int'(s)*W +: W] = data;
        in_data4   = d;
        sel4       = s;
        in_valid4  = iv;
        out_ready4 = ordy;
    endtask

    task automatic drive3(input logic iv, input logic [1:0] s, input logic clr);
        in_valid3 = iv;
        sel3      = s;
        err_clr3  = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive4(1'b0, 2'd0, 64'hA0, 1'b0);
        err_clr4   = 1'b0;
        in_data3   = {64'h33, 64'h32, 64'h31};
        out_ready3 = 1'b1;
        drive3(1'b0, 2'd0, 1'b0);

        //              iv    sel   data     ordy  ev    ed       er    ec
        vecs[0]  = '{1'b1, 2'd0, 64'hA0, 1'b1, 1'b1, 64'hA0, 1'b1, 16'd0};
        vecs[1]  = '{1'b1, 2'd1, 64'hA1, 1'b1, 1'b1, 64'hA1, 1'b1, 16'd1};
        vecs[2]  = '{1'b1, 2'd2, 64'hA2, 1'b1, 1'b1, 64'hA2, 1'b1, 16'd2};
        vecs[3]  = '{1'b1, 2'd3, 64'hA3, 1'b1, 1'b1, 64'hA3, 1'b1, 16'd3};
        vecs[4]  = '{1'b0, 2'd0, 64'hA0, 1'b1, 1'b0, 64'h0,  1'b1, 16'd4};
        vecs[5]  = '{1'b1, 2'd0, 64'h11, 1'b0, 1'b1, 64'h11, 1'b1, 16'd4};
        vecs[6]  = '{1'b1, 2'd1, 64'h22, 1'b0, 1'b1, 64'h11, 1'b0, 16'd4};
        vecs[7]  = '{1'b1, 2'd2, 64'h33, 1'b0, 1'b1, 64'h11, 1'b0, 16'd4};
        vecs[8]  = '{1'b1, 2'd3, 64'h44, 1'b0, 1'b1, 64'h11, 1'b0, 16'd4};
        vecs[9]  = '{1'b1, 2'd0, 64'h55, 1'b1, 1'b1, 64'h22, 1'b1, 16'd5};
        vecs[10] = '{1'b0, 2'd0, 64'h66, 1'b1, 1'b0, 64'h0,  1'b1, 16'd6};

        // Reset values, before any clock edge.
        #2;
        chk("rst_out_valid", 64'(out_valid4), 64'h0);
        chk("rst_out_data",  out_data4, 64'h0);
        chk("rst_in_ready",  64'(in_ready4), 64'h1);
        chk("rst_sel_err",   64'(sel_err4), 64'h0);
        chk("rst_xfer_cnt",  64'(xfer_cnt4), 64'h0);
        step();
        rst_n = 1'b1;

        // Streaming then backpressure with hold stability.
        for (int v = 0; v < 11; v++) begin
            drive4(vecs[v].iv, vecs[v].sel, vecs[v].data, vecs[v].ordy);
            step();
            chk($sformatf("vec%0d_out_valid", v), 64'(out_valid4), 64'(vecs[v].ev));
            if (vecs[v].ev)
                chk($sformatf("vec%0d_out_data", v), out_data4, vecs[v].ed);
            chk($sformatf("vec%0d_in_ready", v), 64'(in_ready4), 64'(vecs[v].er));
            chk($sformatf("vec%0d_xfer_cnt", v), 64'(xfer_cnt4), 64'(vecs[v].ec));
        end

        // Reset mid-operation with both stages loaded.
        drive4(1'b1, 2'd0, 64'h77, 1'b0);
        step();
        drive4(1'b1, 2'd1, 64'h88, 1'b0);
        step();
        chk("pre_rst_in_ready", 64'(in_ready4), 64'h0);
        chk("pre_rst_out_data", out_data4, 64'h77);
        pulse_reset();
        chk("mid_rst_out_valid", 64'(out_valid4), 64'h0);
        chk("mid_rst_out_data",  out_data4, 64'h0);
        chk("mid_rst_in_ready",  64'(in_ready4), 64'h1);
        chk("mid_rst_xfer_cnt",  64'(xfer_cnt4), 64'h0);
        drive4(1'b1, 2'd0, 64'h5, 1'b1);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_out_valid", 64'(out_valid4), 64'h1);
        chk("post_rst_out_data",  out_data4, 64'h5);
        drive4(1'b0, 2'd0, 64'h5, 1'b1);
        step();
        chk("post_rst_alone", 64'(out_valid4), 64'h0);
        chk("post_rst_cnt",   64'(xfer_cnt4), 64'h1);

        // Counter wrap: continuous streaming from empty, first edge only loads.
        pulse_reset();
        drive4(1'b1, 2'd2, 64'h99, 1'b1);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 65536; k++) @(posedge clk);
        #1;
        chk("cnt_ffff", 64'(xfer_cnt4), 64'hFFFF);
        step();
        chk("cnt_wrap", 64'(xfer_cnt4), 64'h0);
        chk("cnt_wrap_valid", 64'(out_valid4), 64'h1);
        drive4(1'b0, 2'd0, 64'h0, 1'b1);

        // Out-of-range select on the three-channel instance.
        drive3(1'b1, 2'd3, 1'b0);
        step();
        chk("oor_out_data",  out_data3, 64'h0);
        chk("oor_out_valid", 64'(out_valid3), 64'h1);
        chk("oor_sel_err",   64'(sel_err3), 64'h1);
        drive3(1'b0, 2'd0, 1'b0);
        step();
        chk("oor_sticky", 64'(sel_err3), 64'h1);
        drive3(1'b1, 2'd1, 1'b0);
        step();
        chk("inrange_data",   out_data3, 64'h32);
        chk("inrange_sticky", 64'(sel_err3), 64'h1);
        drive3(1'b0, 2'd0, 1'b1);
        step();
        chk("clr_alone", 64'(sel_err3), 64'h0);
        drive3(1'b1, 2'd3, 1'b1);
        step();
        chk("set_and_clr", 64'(sel_err3), 64'h1);
        drive3(1'b0, 2'd0, 1'b1);
        step();
        chk("clr_again", 64'(sel_err3), 64'h0);
        chk("n3_xfer_cnt", 64'(xfer_cnt3), 64'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
